// File: rtl/apb_fsm_controller.sv
// APB3 sequencing stage of the AHB-to-APB bridge: turns one accepted AHB
// address phase at a time into APB SETUP/ACCESS phases and stalls the master.
module apb_fsm_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SEL    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic [NUM_SEL-1:0]    tempsel,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    output logic [NUM_SEL-1:0]    pselx,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  penable,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WWAIT   = 3'd1,
        WRITE   = 3'd2,
        WENABLE = 3'd3,
        READ    = 3'd4,
        RENABLE = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [NUM_SEL-1:0]    sel_q;
    logic [NUM_SEL-1:0]    sel_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [NUM_SEL-1:0]    pselx_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  pwrite_nxt;
    logic                  penable_nxt;
    logic                  accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            paddr   <= '0;
            pselx   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            penable <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            sel_q   <= sel_nxt;
            paddr   <= paddr_nxt;
            pselx   <= pselx_nxt;
            pwdata  <= pwdata_nxt;
            pwrite  <= pwrite_nxt;
            penable <= penable_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        sel_nxt     = sel_q;
        paddr_nxt   = paddr;
        pselx_nxt   = pselx;
        pwdata_nxt  = pwdata;
        pwrite_nxt  = pwrite;
        penable_nxt = penable;
        hreadyout   = 1'b1;
        hrdata      = '0;
        accept      = 1'b0;

        unique case (state)
            IDLE: accept = 1'b1;
            WWAIT: begin
                hreadyout = 1'b0;
                state_nxt = WRITE;
            end
            WRITE: begin
                hreadyout = 1'b0;
                state_nxt = WENABLE;
            end
            WENABLE: begin
                hreadyout = pready;
                accept    = pready;
            end
            READ: begin
                hreadyout = 1'b0;
                state_nxt = RENABLE;
            end
            RENABLE: begin
                hreadyout = pready;
                hrdata    = prdata;
                accept    = pready;
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            if (valid) begin
                addr_nxt  = haddr;
                sel_nxt   = tempsel;
                state_nxt = hwrite ? WWAIT : READ;
            end else begin
                state_nxt = IDLE;
            end
        end

        // APB outputs are set by the state being entered; ENABLE states that
        // stall re-enter themselves and so keep every strobe unchanged.
        case (state_nxt)
            IDLE, WWAIT: begin
                pselx_nxt   = '0;
                penable_nxt = 1'b0;
            end
            READ: begin
                paddr_nxt   = haddr;
                pselx_nxt   = tempsel;
                pwrite_nxt  = 1'b0;
                penable_nxt = 1'b0;
            end
            WRITE: begin
                paddr_nxt   = addr_q;
                pselx_nxt   = sel_q;
                pwrite_nxt  = 1'b1;
                pwdata_nxt  = hwdata;
                penable_nxt = 1'b0;
            end
            WENABLE, RENABLE: penable_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed and random AHB
// transfers checked cycle by cycle against a transfer-level APB model.
module tb_apb_fsm_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          valid   = 1'b0;
    logic [AW-1:0] haddr   = '0;
    logic          hwrite  = 1'b0;
    logic [DW-1:0] hwdata  = '0;
    logic [NS-1:0] tempsel = '0;
    logic [DW-1:0] prdata  = '0;
    logic          pready  = 1'b1;
    logic [NS-1:0] pselx;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          penable;
    logic          hreadyout;
    logic [DW-1:0] hrdata;

    always #5 clk = ~clk;

    apb_fsm_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_SEL   (NS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .hwdata   (hwdata),
        .tempsel  (tempsel),
        .prdata   (prdata),
        .pready   (pready),
        .pselx    (pselx),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .penable  (penable),
        .hreadyout(hreadyout),
        .hrdata   (hrdata)
    );

    // One AHB transfer: data is write data or the read data the slave returns;
    // waits is the number of pready=0 ACCESS cycles.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] data;
        int unsigned waits;
    } xfer_t;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // APB values that persist between transfers
    logic [31:0] m_paddr  = '0;
    logic [31:0] m_pwdata = '0;
    logic        m_pwrite = 1'b0;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s.%s: observed 0x%08h, expected 0x%08h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [2:0] sel, input logic en,
                             input logic rdy, input logic [31:0] rd);
        chk(tag, "pselx",     32'(pselx),     32'(sel));
        chk(tag, "paddr",     paddr,          m_paddr);
        chk(tag, "pwdata",    pwdata,         m_pwdata);
        chk(tag, "pwrite",    32'(pwrite),    32'(m_pwrite));
        chk(tag, "penable",   32'(penable),   32'(en));
        chk(tag, "hreadyout", 32'(hreadyout), 32'(rdy));
        chk(tag, "hrdata",    hrdata,         rd);
    endtask

    task automatic drive_addr(input xfer_t x);
        valid   = 1'b1;
        haddr   = x.addr;
        hwrite  = x.wr;
        tempsel = x.sel;
    endtask

    task automatic no_addr();
        valid   = 1'b0;
        haddr   = $urandom;
        hwrite  = 1'($urandom);
        tempsel = 3'($urandom);
    endtask

    // Address-phase lines while the controller must ignore them
    task automatic junk();
        valid   = 1'($urandom);
        haddr   = $urandom;
        hwrite  = 1'($urandom);
        tempsel = 3'($urandom);
    endtask

    task automatic cycle_idle(input bit pres, input xfer_t x);
        @(posedge clk);
        #1;
        if (pres) drive_addr(x);
        else no_addr();
        pready = 1'($urandom);
        prdata = $urandom;
        @(negedge clk);
        check_bus("idle", 3'b000, 1'b0, 1'b1, 32'h0);
    endtask

    // Data phase of x, whose address was accepted on the previous edge.
    // The last cycle optionally presents nx as the next address phase.
    task automatic run(input xfer_t x, input bit has_next, input xfer_t nx);
        if (x.wr) begin
            @(posedge clk);
            #1;
            junk();
            hwdata = x.data;
            pready = 1'($urandom);
            @(negedge clk);
            check_bus("wwait", 3'b000, 1'b0, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            junk();
            hwdata   = $urandom;
            m_paddr  = x.addr;
            m_pwdata = x.data;
            m_pwrite = 1'b1;
            @(negedge clk);
            check_bus("wsetup", x.sel, 1'b0, 1'b0, 32'h0);
        end else begin
            @(posedge clk);
            #1;
            junk();
            pready   = 1'($urandom);
            prdata   = $urandom;
            m_paddr  = x.addr;
            m_pwrite = 1'b0;
            @(negedge clk);
            check_bus("rsetup", x.sel, 1'b0, 1'b0, 32'h0);
        end
        for (int unsigned i = 0; i < x.waits; i++) begin
            @(posedge clk);
            #1;
            junk();
            pready = 1'b0;
            prdata = $urandom;
            @(negedge clk);
            check_bus(x.wr ? "wstall" : "rstall", x.sel, 1'b1, 1'b0, x.wr ? 32'h0 : prdata);
        end
        @(posedge clk);
        #1;
        if (has_next) drive_addr(nx);
        else no_addr();
        pready = 1'b1;
        prdata = x.wr ? $urandom : x.data;
        @(negedge clk);
        check_bus(x.wr ? "waccess" : "raccess", x.sel, 1'b1, 1'b1, x.wr ? 32'h0 : x.data);
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t       x;
        int unsigned r;
        r       = $urandom_range(0, 9);
        x.wr    = 1'($urandom);
        x.addr  = $urandom;
        x.sel   = (r == 0) ? 3'b000 : 3'(3'b001 << (r % 3));
        x.data  = $urandom;
        x.waits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        xfer_t rd0, wr0, wr1, rb, wb, cur, nxt, dummy;

        dummy = '{wr: 1'b0, addr: 32'h0, sel: 3'b000, data: 32'h0, waits: 0};

        // reset state
        #2;
        check_bus("reset", 3'b000, 1'b0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (5) cycle_idle(1'b0, dummy);

        // single zero-wait read
        rd0 = '{wr: 1'b0, addr: 32'h8000_0010, sel: 3'b001, data: 32'hDEAD_BEEF, waits: 0};
        cycle_idle(1'b1, rd0);
        run(rd0, 1'b0, dummy);
        cycle_idle(1'b0, dummy);

        // single zero-wait write
        wr0 = '{wr: 1'b1, addr: 32'h8400_0004, sel: 3'b010, data: 32'h1234_5678, waits: 0};
        cycle_idle(1'b1, wr0);
        run(wr0, 1'b0, dummy);
        cycle_idle(1'b0, dummy);

        // write stalled for three ACCESS cycles
        wr1 = '{wr: 1'b1, addr: 32'h8800_0000, sel: 3'b100, data: 32'hCAFE_F00D, waits: 3};
        cycle_idle(1'b1, wr1);
        run(wr1, 1'b0, dummy);
        cycle_idle(1'b0, dummy);

        // read with the following write presented during RENABLE
        rb = '{wr: 1'b0, addr: 32'h8000_0000, sel: 3'b001, data: 32'hA5A5_0001, waits: 0};
        wb = '{wr: 1'b1, addr: 32'h8400_0008, sel: 3'b010, data: 32'h0BAD_C0DE, waits: 0};
        cycle_idle(1'b1, rb);
        run(rb, 1'b1, wb);
        run(wb, 1'b0, dummy);
        cycle_idle(1'b0, dummy);

        // reset asserted while a write is stalled in ACCESS
        cycle_idle(1'b1, wr1);
        @(posedge clk);
        #1;
        junk();
        hwdata = 32'h7777_0000;
        @(negedge clk);
        check_bus("rst_wwait", 3'b000, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        junk();
        m_paddr  = wr1.addr;
        m_pwdata = 32'h7777_0000;
        m_pwrite = 1'b1;
        @(negedge clk);
        check_bus("rst_wsetup", wr1.sel, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        no_addr();
        pready = 1'b0;
        @(negedge clk);
        check_bus("rst_wstall", wr1.sel, 1'b1, 1'b0, 32'h0);
        #2;
        rst_n    = 1'b0;
        m_paddr  = '0;
        m_pwdata = '0;
        m_pwrite = 1'b0;
        #1;
        check_bus("rst_mid", 3'b000, 1'b0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle_idle(1'b0, dummy);

        // random traffic, chained or separated by idle gaps
        cur = rand_xfer();
        cycle_idle(1'b1, cur);
        for (int n = 0; n < 60; n++) begin
            bit chain;
            nxt   = rand_xfer();
            chain = 1'($urandom);
            run(cur, chain, nxt);
            if (!chain) begin
                repeat ($urandom_range(0, 2)) cycle_idle(1'b0, dummy);
                cycle_idle(1'b1, nxt);
            end
            cur = nxt;
        end
        run(cur, 1'b0, dummy);
        cycle_idle(1'b0, dummy);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
